// File: rtl/apb_pkg.sv
// Shared APB completer definitions: default widths, FSM state type and
// byte-lane / alignment helpers used by the register-bank completer.
package apb_pkg;

    localparam int APB_ADDR_WIDTH = 32;
    localparam int APB_DATA_WIDTH = 32;
    localparam int APB_STRB_WIDTH = APB_DATA_WIDTH / 8;
    localparam int APB_ALIGNBITS  = $clog2(APB_STRB_WIDTH);

    typedef enum logic {
        IDLE,
        ACCESS
    } apb_state_e;

    // Only the low ALIGNBITS address bits matter; ALIGNBITS=0 is always aligned.
    function automatic logic is_aligned(input logic [1:0] lsb, input int alignbits);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (i < alignbits && lsb[i]) ok = 1'b0;
        end
        return ok;
    endfunction

    // Widest legal bus is 32 bits; narrower buses use the low lanes.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] m;
        m = old_word;
        for (int n = 0; n < 4; n++) begin
            if (strb[n]) m[8*n +: 8] = new_word[8*n +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/apb_regbank.sv
// DEPTH x DATA_WIDTH register storage: async clear, byte-enabled indexed
// write, combinational indexed read.
module apb_regbank
    import apb_pkg::*;
#(
    parameter  int DATA_WIDTH = APB_DATA_WIDTH,
    parameter  int DEPTH      = 16,
    localparam int IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int SW         = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IW-1:0]         widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [SW-1:0]         wstrb,
    input  logic [IW-1:0]         ridx,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [31:0]           merged32;
    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        merged32 = merge_bytes(32'(mem[widx]), 32'(wdata), 4'(wstrb));
        merged   = merged32[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            mem[widx] <= merged;
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/apb_completer_regbank.sv
// APB4 completer in front of a register bank: wait-state FSM, address decode,
// PSLVERR on misaligned/out-of-range accesses, byte-lane writes via PSTRB.
module apb_completer_regbank
    import apb_pkg::*;
#(
    parameter  int                    ADDR_WIDTH  = APB_ADDR_WIDTH,
    parameter  int                    DATA_WIDTH  = APB_DATA_WIDTH,
    parameter  int                    DEPTH       = 16,
    parameter  int                    WAIT_CYCLES = 0,
    parameter  logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    localparam int                    STRB_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [STRB_WIDTH-1:0] PSTRB,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR
);

    localparam int ALIGNBITS = $clog2(STRB_WIDTH);
    localparam int CW        = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_state_e            state, state_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0] offset, word;
    logic                  below, out_of_range, misaligned, err, done;
    logic [DATA_WIDTH-1:0] rdata;

    // Decode runs every cycle but only matters in the completion cycle.
    assign offset       = PADDR - BASE_ADDR;
    assign word         = offset >> ALIGNBITS;
    assign below        = PADDR < BASE_ADDR;
    assign out_of_range = below || (word >= ADDR_WIDTH'(DEPTH));
    assign misaligned   = !is_aligned(PADDR[1:0], ALIGNBITS);
    assign err          = misaligned || out_of_range;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done      = 1'b0;
        case (state)
            IDLE: begin
                // PSEL with PENABLE and no setup phase is ignored here.
                if (PSEL && !PENABLE) begin
                    state_nxt = ACCESS;
                    cnt_nxt   = '0;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (PENABLE) begin
                    if (cnt == CW'(WAIT_CYCLES)) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end else begin
                    cnt_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign PREADY  = done && !PRESET;
    assign PSLVERR = PREADY && err;
    assign PRDATA  = (PREADY && !PWRITE && !err) ? rdata : '0;

    apb_regbank #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH)
    ) u_regbank (
        .clk  (PCLK),
        .rst  (PRESET),
        .we   (PREADY && PWRITE && !err),
        .widx (word[IW-1:0]),
        .wdata(PWDATA),
        .wstrb(PSTRB),
        .ridx (word[IW-1:0]),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_apb_completer_regbank.sv
// Directed bench: three completers (0, 3 and 2 wait states) on one shared
// APB bus with per-instance PSEL; expected values are hand-computed.
module tb_apb_completer_regbank;

    logic        pclk = 1'b0;
    logic        preset;
    logic [2:0]  psel;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pready, pslverr;
    logic [31:0] prdata0, prdata1, prdata2;

    int checks = 0;
    int errors = 0;

    always #5 pclk = ~pclk;

    apb_completer_regbank #(.WAIT_CYCLES(0)) u_w0 (
        .PCLK(pclk), .PRESET(preset), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready[0]), .PRDATA(prdata0), .PSLVERR(pslverr[0]));

    apb_completer_regbank #(.WAIT_CYCLES(3)) u_w3 (
        .PCLK(pclk), .PRESET(preset), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready[1]), .PRDATA(prdata1), .PSLVERR(pslverr[1]));

    apb_completer_regbank #(.WAIT_CYCLES(2)) u_w2 (
        .PCLK(pclk), .PRESET(preset), .PSEL(psel[2]), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
        .PREADY(pready[2]), .PRDATA(prdata2), .PSLVERR(pslverr[2]));

    function automatic logic [31:0] rdat(input int d);
        case (d)
            0:       return prdata0;
            1:       return prdata1;
            default: return prdata2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Setup cycle, then access cycles until PREADY (bounded); cyc counts both.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb,
                        output logic [31:0] rd, output logic er, output int cyc);
        rd = '0;
        er = 1'b0;
        @(posedge pclk); #1;
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr;
        paddr = addr; pwdata = wd; pstrb = strb;
        cyc = 1;
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc = 2;
        for (int k = 0; k < 40; k++) begin
            @(negedge pclk);
            if (pready[d]) begin
                rd = rdat(d);
                er = pslverr[d];
                break;
            end
            @(posedge pclk); #1;
            cyc++;
        end
        @(posedge pclk); #1;
        psel[d] = 1'b0; penable = 1'b0;
    endtask

    task automatic do_wr(input string tag, input int d, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] strb,
                         input logic exp_err, input int exp_cyc);
        logic [31:0] rd;
        logic        er;
        int          cyc;
        xfer(d, 1'b1, addr, wd, strb, rd, er, cyc);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        check({tag, "_cyc"}, cyc, exp_cyc);
    endtask

    task automatic do_rd(input string tag, input int d, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic exp_err, input int exp_cyc);
        logic [31:0] rd;
        logic        er;
        int          cyc;
        xfer(d, 1'b0, addr, 32'h0, 4'h0, rd, er, cyc);
        check({tag, "_data"}, rd, exp_data);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        check({tag, "_cyc"}, cyc, exp_cyc);
    endtask

    initial begin
        preset = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;

        // Reset state, with a setup cycle presented during reset.
        @(posedge pclk); #1;
        psel[0] = 1'b1;
        @(negedge pclk);
        check("rst_pready", 32'(pready), 32'h0);
        check("rst_pslverr", 32'(pslverr), 32'h0);
        check("rst_prdata", prdata0, 32'h0);
        @(posedge pclk); #1;
        psel = '0;
        preset = 1'b0;

        // Zero wait states: full write then read, 2 cycles each.
        do_wr("t1_wr", 0, 32'h08, 32'hDEADBEEF, 4'hF, 1'b0, 2);
        do_rd("t1_rd", 0, 32'h08, 32'hDEADBEEF, 1'b0, 2);

        // Byte-lane merge.
        do_wr("t2_wr0", 0, 32'h04, 32'h11223344, 4'hF, 1'b0, 2);
        do_wr("t2_wr1", 0, 32'h04, 32'hAABBCCDD, 4'b0101, 1'b0, 2);
        do_rd("t2_rd", 0, 32'h04, 32'h11BB33DD, 1'b0, 2);

        // PSTRB=0 is a no-op write without error.
        do_wr("strb0_wr", 0, 32'h08, 32'h01234567, 4'h0, 1'b0, 2);
        do_rd("strb0_rd", 0, 32'h08, 32'hDEADBEEF, 1'b0, 2);

        // Three wait states: 5 cycles from setup to completion.
        do_rd("t3_rd0", 1, 32'h00, 32'h0, 1'b0, 5);
        do_wr("t3_wr", 1, 32'h00, 32'h5A5A5A5A, 4'hF, 1'b0, 5);
        do_rd("t3_rd1", 1, 32'h00, 32'h5A5A5A5A, 1'b0, 5);

        // Error responses and boundary addresses.
        do_wr("t4_mis_wr", 0, 32'h06, 32'hFFFFFFFF, 4'hF, 1'b1, 2);
        do_wr("t4_oor_wr", 0, 32'h40, 32'hFFFFFFFF, 4'hF, 1'b1, 2);
        do_rd("t4_mis_rd", 0, 32'h06, 32'h0, 1'b1, 2);
        do_rd("t4_oor_rd", 0, 32'h40, 32'h0, 1'b1, 2);
        do_rd("t4_chk04", 0, 32'h04, 32'h11BB33DD, 1'b0, 2);
        do_rd("t4_chk00", 0, 32'h00, 32'h0, 1'b0, 2);
        do_wr("t4_last_wr", 0, 32'h3C, 32'hCAFEF00D, 4'hF, 1'b0, 2);
        do_rd("t4_last_rd", 0, 32'h3C, 32'hCAFEF00D, 1'b0, 2);

        // Requester drops PSEL mid-wait: no write.
        @(posedge pclk); #1;
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h10; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        check("t6_abort_wait", 32'(pready[2]), 32'h0);
        @(posedge pclk); #1;
        psel[2] = 1'b0; penable = 1'b0;
        @(negedge pclk);
        check("t6_abort_drop", 32'(pready[2]), 32'h0);
        do_rd("t6_abort_rd", 2, 32'h10, 32'h0, 1'b0, 4);

        // PSEL+PENABLE from IDLE with no setup phase.
        @(posedge pclk); #1;
        psel[2] = 1'b1; penable = 1'b1; pwrite = 1'b1;
        paddr = 32'h10; pwdata = 32'h12345678; pstrb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check("t6_viol_pready", 32'(pready[2]), 32'h0);
            @(posedge pclk); #1;
        end
        psel[2] = 1'b0; penable = 1'b0;
        do_rd("t6_viol_rd", 2, 32'h10, 32'h0, 1'b0, 4);

        // Reset during the 2nd access cycle of a two-wait-state write.
        @(posedge pclk); #1;
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h0C; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        @(negedge pclk);
        check("t5_rst_pready", 32'(pready[2]), 32'h0);
        check("t5_rst_pslverr", 32'(pslverr[2]), 32'h0);
        @(posedge pclk); #1;
        @(negedge pclk);
        check("t5_rst_hold", 32'(pready[2]), 32'h0);
        @(posedge pclk); #1;
        preset = 1'b0;
        psel[2] = 1'b0; penable = 1'b0;
        do_rd("t5_rd0c", 2, 32'h0C, 32'h0, 1'b0, 4);
        do_wr("t5_wr", 2, 32'h0C, 32'h0BADF00D, 4'hF, 1'b0, 4);
        do_rd("t5_rd_after", 2, 32'h0C, 32'h0BADF00D, 1'b0, 4);
        do_rd("t5_w0_cleared", 0, 32'h08, 32'h0, 1'b0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
